// File: rtl/sdr_pkg.sv
// Shared SDR datapath definitions: sample/IQ-pair widths, field positions
// and helpers for packing and unpacking IQ pairs.
package sdr_pkg;

    localparam int SDR_SAMPLE_WIDTH = 12;
    localparam int SDR_MAX_LOG2     = 4;
    localparam int SDR_ACC_WIDTH    = SDR_SAMPLE_WIDTH + SDR_MAX_LOG2;
    localparam int SDR_PAIR_WIDTH   = 2 * SDR_SAMPLE_WIDTH;
    localparam int SDR_LOG2_WIDTH   = 3;

    localparam int I_LSB = 0;
    localparam int I_MSB = SDR_SAMPLE_WIDTH - 1;
    localparam int Q_LSB = SDR_SAMPLE_WIDTH;
    localparam int Q_MSB = 2 * SDR_SAMPLE_WIDTH - 1;

    typedef logic signed [SDR_SAMPLE_WIDTH-1:0] sample_t;
    typedef logic        [SDR_PAIR_WIDTH-1:0]   iq_pair_t;

    function automatic sample_t iq_i(input iq_pair_t pair);
        return sample_t'(pair[I_MSB:I_LSB]);
    endfunction

    function automatic sample_t iq_q(input iq_pair_t pair);
        return sample_t'(pair[Q_MSB:Q_LSB]);
    endfunction

    function automatic iq_pair_t iq_pack(input sample_t i_val, input sample_t q_val);
        return {q_val, i_val};
    endfunction

endpackage

// File: rtl/iq_accum.sv
// Single-channel signed block accumulator: loads on the first sample of a
// block, adds later ones, and presents the floor-scaled block sum.
module iq_accum
    import sdr_pkg::*;
#(
    parameter int SW = SDR_SAMPLE_WIDTH,
    parameter int AW = SDR_ACC_WIDTH,
    parameter int LW = SDR_LOG2_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 accept,
    input  logic                 first,
    input  logic signed [SW-1:0] sample,
    input  logic        [LW-1:0] shift,
    output logic signed [SW-1:0] result
);

    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] sample_ext;
    logic signed [AW-1:0] sum;

    assign sample_ext = {{(AW-SW){sample[SW-1]}}, sample};
    assign sum        = first ? sample_ext : acc_q + sample_ext;

    // Arithmetic shift floors toward minus infinity; the average always fits SW bits.
    assign result = SW'(sum >>> shift);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (accept) begin
            acc_q <= sum;
        end
    end

endmodule

// File: rtl/iq_decim.sv
// Power-of-two block-average decimator for packed IQ samples feeding the a2f
// FIFO, with sticky overflow flag and saturating drop counter.
module iq_decim
    import sdr_pkg::*;
#(
    parameter int IQ_PAIR_WIDTH = SDR_PAIR_WIDTH,
    parameter int SAMPLE_WIDTH  = SDR_SAMPLE_WIDTH,
    parameter int MAX_LOG2      = SDR_MAX_LOG2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    input  logic [2:0]               decim_log2_i,
    input  logic [IQ_PAIR_WIDTH-1:0] in_data_i,
    input  logic                     in_valid_i,
    input  logic                     fifo_full_i,
    input  logic                     clr_i,
    output logic [IQ_PAIR_WIDTH-1:0] out_data_o,
    output logic                     out_we_o,
    output logic                     overflow_o,
    output logic [15:0]              drop_cnt_o
);

    localparam int ACC_WIDTH = SAMPLE_WIDTH + MAX_LOG2;
    localparam logic [MAX_LOG2:0] ONE = 1;

    // Handshake: valid-only input, one sample per in_valid_i cycle while
    // enabled, no back-pressure toward the AFE. Output strobe is gated by
    // fifo_full_i in the output cycle; a gated strobe is counted as a drop.
    logic                    accept;
    logic                    first;
    logic                    last;
    logic [2:0]              eff_log2;
    logic [2:0]              blk_log2;
    logic [MAX_LOG2:0]       n_m1;
    logic [MAX_LOG2-1:0]     cnt_q;
    logic [2:0]              log2_q;
    logic                    pend_q;
    logic                    drop;
    logic [SAMPLE_WIDTH-1:0] res_i;
    logic [SAMPLE_WIDTH-1:0] res_q;

    assign accept   = enable_i & in_valid_i;
    assign first    = (cnt_q == '0);
    assign eff_log2 = (decim_log2_i > 3'(MAX_LOG2)) ? 3'(MAX_LOG2) : decim_log2_i;
    // The block ratio is taken live on its first sample and latched after that.
    assign blk_log2 = first ? eff_log2 : log2_q;
    assign n_m1     = (ONE << blk_log2) - ONE;
    assign last     = ({1'b0, cnt_q} == n_m1);

    iq_accum #(
        .SW(SAMPLE_WIDTH),
        .AW(ACC_WIDTH),
        .LW(3)
    ) u_accum_i (
        .clk   (clk_i),
        .rst   (rst_i),
        .accept(accept),
        .first (first),
        .sample(iq_i(in_data_i)),
        .shift (blk_log2),
        .result(res_i)
    );

    iq_accum #(
        .SW(SAMPLE_WIDTH),
        .AW(ACC_WIDTH),
        .LW(3)
    ) u_accum_q (
        .clk   (clk_i),
        .rst   (rst_i),
        .accept(accept),
        .first (first),
        .sample(iq_q(in_data_i)),
        .shift (blk_log2),
        .result(res_q)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            log2_q     <= '0;
            pend_q     <= 1'b0;
            out_data_o <= '0;
        end else begin
            pend_q <= accept & last;
            if (!enable_i) begin
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q <= last ? '0 : cnt_q + 1'b1;
                if (first) begin
                    log2_q <= eff_log2;
                end
            end
            if (accept && last) begin
                out_data_o <= iq_pack(res_i, res_q);
            end
        end
    end

    assign out_we_o = pend_q & ~fifo_full_i;
    assign drop     = pend_q & fifo_full_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else if (clr_i) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else if (drop) begin
            overflow_o <= 1'b1;
            if (drop_cnt_o != 16'hFFFF) begin
                drop_cnt_o <= drop_cnt_o + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_iq_decim.sv
// Self-checking bench for iq_decim: directed scenarios plus a randomized run,
// checked against a block-averaging reference model built from queues.
module tb_iq_decim;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [2:0]  decim_log2 = 3'd0;
    logic [23:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        fifo_full = 1'b0;
    logic        clr = 1'b0;
    logic [23:0] out_data;
    logic        out_we;
    logic        overflow;
    logic [15:0] drop_cnt;

    iq_decim dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .enable_i    (enable),
        .decim_log2_i(decim_log2),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .fifo_full_i (fifo_full),
        .clr_i       (clr),
        .out_data_o  (out_data),
        .out_we_o    (out_we),
        .overflow_o  (overflow),
        .drop_cnt_o  (drop_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [23:0] d;
        int          t;
    } ev_t;

    ev_t obs_q[$];
    ev_t exp_q[$];
    ev_t pend_q[$];
    int  blk_i[$];
    int  blk_q[$];
    int  blk_n = 1;
    int  m_drop = 0;
    logic m_ovf = 1'b0;

    int checks = 0;
    int failures = 0;
    int obs_rd = 0;
    int exp_rd = 0;

    function automatic logic [11:0] floor_avg(input int s, input int n);
        int q;
        q = s / n;
        if ((s % n) != 0 && s < 0) q = q - 1;
        return q[11:0];
    endfunction

    // Reference model, evaluated mid-cycle on the inputs about to be sampled.
    always @(negedge clk) begin
        ev_t e;
        bit  drop_now;
        int  si;
        int  sq;
        drop_now = 1'b0;
        if (rst) begin
            pend_q.delete();
            blk_i.delete();
            blk_q.delete();
            m_drop = 0;
            m_ovf  = 1'b0;
        end else begin
            if (out_we) obs_q.push_back('{out_data, cyc});
            if (pend_q.size() > 0 && pend_q[0].t == cyc) begin
                e = pend_q.pop_front();
                if (fifo_full) drop_now = 1'b1;
                else exp_q.push_back(e);
            end
            if (clr) begin
                m_drop = 0;
                m_ovf  = 1'b0;
            end else if (drop_now) begin
                m_ovf = 1'b1;
                if (m_drop < 65535) m_drop++;
            end
            if (!enable) begin
                blk_i.delete();
                blk_q.delete();
            end else if (in_valid) begin
                if (blk_i.size() == 0) blk_n = 1 << ((decim_log2 > 4) ? 4 : int'(decim_log2));
                blk_i.push_back(int'($signed(in_data[11:0])));
                blk_q.push_back(int'($signed(in_data[23:12])));
                if (blk_i.size() == blk_n) begin
                    si = 0;
                    sq = 0;
                    foreach (blk_i[k]) si += blk_i[k];
                    foreach (blk_q[k]) sq += blk_q[k];
                    pend_q.push_back('{{floor_avg(sq, blk_n), floor_avg(si, blk_n)}, cyc + 1});
                    blk_i.delete();
                    blk_q.delete();
                end
            end
        end
    end

    // Driver tasks: every task starts and ends 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [11:0] i_val, input logic [11:0] q_val);
        in_data  = {q_val, i_val};
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic start_clean(input logic [2:0] l2);
        enable     = 1'b0;
        decim_log2 = l2;
        idle(1);
        enable = 1'b1;
    endtask

    task automatic test_reset();
        idle(2);
        checks++; if (out_data !== 24'h0) begin failures++; $display("FAIL reset_data: got %h expected %h", out_data, 24'h0); end
        checks++; if (out_we !== 1'b0) begin failures++; $display("FAIL reset_we: got %b expected 0", out_we); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
        checks++; if (drop_cnt !== 16'h0) begin failures++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
        rst = 1'b0;
        start_clean(3'd2);
        send(12'd50, 12'd50);
        send(12'd60, 12'd60);
        rst = 1'b1;
        idle(1);
        checks++; if (out_we !== 1'b0 || out_data !== 24'h0) begin failures++; $display("FAIL midblock_reset: got we=%b data=%h expected we=0 data=0", out_we, out_data); end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) send(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
        idle(3);
        begin
            int no = obs_q.size() - obs_rd;
            int ne = exp_q.size() - exp_rd;
            checks++; if (no !== 1 || ne !== 1) begin failures++; $display("FAIL midblock_count: got %0d model %0d expected 1", no, ne); end
            for (int k = 0; k < no && k < ne; k++) begin
                checks++;
                if (obs_q[obs_rd+k].d !== exp_q[exp_rd+k].d || obs_q[obs_rd+k].t !== exp_q[exp_rd+k].t) begin
                    failures++; $display("FAIL midblock_data: got %h@%0d expected %h@%0d", obs_q[obs_rd+k].d, obs_q[obs_rd+k].t, exp_q[exp_rd+k].d, exp_q[exp_rd+k].t);
                end
            end
            obs_rd = obs_q.size(); exp_rd = exp_q.size();
        end
    endtask

    task automatic test_avg4();
        int t4;
        start_clean(3'd2);
        send(12'd100, 12'hFFC);
        send(12'd200, 12'hFFC);
        send(12'd300, 12'hFFC);
        send(12'd400, 12'hFFC);
        t4 = cyc;
        idle(3);
        checks++; if (obs_q.size() - obs_rd !== 1) begin failures++; $display("FAIL avg4_count: got %0d expected 1", obs_q.size() - obs_rd); end
        if (obs_q.size() > obs_rd) begin
            checks++; if (obs_q[obs_rd].d !== 24'hFFC0FA) begin failures++; $display("FAIL avg4_data: got %h expected %h", obs_q[obs_rd].d, 24'hFFC0FA); end
            checks++; if (obs_q[obs_rd].t !== t4) begin failures++; $display("FAIL avg4_latency: got cycle %0d expected %0d", obs_q[obs_rd].t, t4); end
        end
        obs_rd = obs_q.size(); exp_rd = exp_q.size();
    endtask

    task automatic test_floor2();
        start_clean(3'd1);
        send(12'hFFF, 12'd0);
        send(12'd0, 12'd0);
        idle(3);
        checks++; if (obs_q.size() - obs_rd !== 1) begin failures++; $display("FAIL floor2_count: got %0d expected 1", obs_q.size() - obs_rd); end
        if (obs_q.size() > obs_rd) begin
            checks++; if (obs_q[obs_rd].d[11:0] !== 12'hFFF) begin failures++; $display("FAIL floor2_i: got %h expected %h", obs_q[obs_rd].d[11:0], 12'hFFF); end
        end
        obs_rd = obs_q.size(); exp_rd = exp_q.size();
    endtask

    task automatic test_pass1();
        logic [23:0] sent[$];
        int          tsent[$];
        start_clean(3'd0);
        for (int k = 0; k < 10; k++) begin
            logic [23:0] v;
            v = 24'($urandom);
            sent.push_back(v);
            send(v[11:0], v[23:12]);
            tsent.push_back(cyc);
            idle($urandom_range(0, 2));
        end
        idle(2);
        checks++; if (obs_q.size() - obs_rd !== 10) begin failures++; $display("FAIL pass1_count: got %0d expected 10", obs_q.size() - obs_rd); end
        for (int k = 0; k < 10 && obs_rd + k < obs_q.size(); k++) begin
            checks++;
            if (obs_q[obs_rd+k].d !== sent[k] || obs_q[obs_rd+k].t !== tsent[k]) begin
                failures++; $display("FAIL pass1_sample%0d: got %h@%0d expected %h@%0d", k, obs_q[obs_rd+k].d, obs_q[obs_rd+k].t, sent[k], tsent[k]);
            end
        end
        obs_rd = obs_q.size(); exp_rd = exp_q.size();
    endtask

    task automatic test_fifo_full();
        start_clean(3'd0);
        fifo_full = 1'b1;
        send(12'd1, 12'd2);
        send(12'd3, 12'd4);
        send(12'd5, 12'd6);
        idle(2);
        fifo_full = 1'b0;
        idle(1);
        checks++; if (obs_q.size() !== obs_rd) begin failures++; $display("FAIL full_no_write: got %0d strobes expected 0", obs_q.size() - obs_rd); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL full_ovf: got %b expected 1", overflow); end
        checks++; if (drop_cnt !== 16'd3) begin failures++; $display("FAIL full_drop: got %0d expected 3", drop_cnt); end
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        checks++; if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin failures++; $display("FAIL full_clr: got ovf=%b drop=%0d expected 0/0", overflow, drop_cnt); end
        fifo_full = 1'b1;
        send(12'd7, 12'd8);
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        fifo_full = 1'b0;
        idle(1);
        checks++; if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin failures++; $display("FAIL clr_priority: got ovf=%b drop=%0d expected 0/0", overflow, drop_cnt); end
        checks++; if (obs_q.size() !== obs_rd) begin failures++; $display("FAIL clr_priority_we: got %0d strobes expected 0", obs_q.size() - obs_rd); end
        obs_rd = obs_q.size(); exp_rd = exp_q.size();
    endtask

    task automatic test_flush();
        start_clean(3'd3);
        for (int k = 0; k < 5; k++) send(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
        enable = 1'b0;
        idle(1);
        enable = 1'b1;
        for (int k = 0; k < 8; k++) send(12'd7, 12'd7);
        idle(3);
        checks++; if (obs_q.size() - obs_rd !== 1) begin failures++; $display("FAIL flush_count: got %0d expected 1", obs_q.size() - obs_rd); end
        if (obs_q.size() > obs_rd) begin
            checks++; if (obs_q[obs_rd].d !== 24'h007007) begin failures++; $display("FAIL flush_data: got %h expected %h", obs_q[obs_rd].d, 24'h007007); end
        end
        checks++; if (overflow !== m_ovf || drop_cnt !== 16'(m_drop)) begin failures++; $display("FAIL flush_stats: got ovf=%b drop=%0d expected %b/%0d", overflow, drop_cnt, m_ovf, m_drop); end
        obs_rd = obs_q.size(); exp_rd = exp_q.size();
    endtask

    task automatic test_log2_change();
        int t4;
        start_clean(3'd2);
        send(12'd10, 12'd20);
        send(12'd30, 12'd40);
        decim_log2 = 3'd0;
        send(12'd50, 12'd60);
        send(12'd70, 12'd80);
        t4 = cyc;
        for (int k = 0; k < 3; k++) send(12'(k + 1), 12'(k + 2));
        idle(3);
        checks++; if (obs_q.size() - obs_rd !== 4) begin failures++; $display("FAIL l2chg_count: got %0d expected 4", obs_q.size() - obs_rd); end
        if (obs_q.size() > obs_rd) begin
            checks++; if (obs_q[obs_rd].d !== 24'h032028 || obs_q[obs_rd].t !== t4) begin
                failures++; $display("FAIL l2chg_first: got %h@%0d expected %h@%0d", obs_q[obs_rd].d, obs_q[obs_rd].t, 24'h032028, t4);
            end
        end
        for (int k = 0; k < obs_q.size() - obs_rd && k < exp_q.size() - exp_rd; k++) begin
            checks++;
            if (obs_q[obs_rd+k].d !== exp_q[exp_rd+k].d || obs_q[obs_rd+k].t !== exp_q[exp_rd+k].t) begin
                failures++; $display("FAIL l2chg_model%0d: got %h@%0d expected %h@%0d", k, obs_q[obs_rd+k].d, obs_q[obs_rd+k].t, exp_q[exp_rd+k].d, exp_q[exp_rd+k].t);
            end
        end
        obs_rd = obs_q.size(); exp_rd = exp_q.size();
    endtask

    task automatic test_random();
        start_clean(3'($urandom_range(0, 7)));
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 15) == 0) decim_log2 = 3'($urandom_range(0, 7));
            enable    = ($urandom_range(0, 49) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 24'($urandom);
            fifo_full = ($urandom_range(0, 9) == 0);
            clr       = ($urandom_range(0, 99) == 0);
            idle(1);
        end
        in_valid  = 1'b0;
        fifo_full = 1'b0;
        clr       = 1'b0;
        enable    = 1'b1;
        idle(3);
        begin
            int no = obs_q.size() - obs_rd;
            int ne = exp_q.size() - exp_rd;
            checks++; if (no !== ne) begin failures++; $display("FAIL random_count: got %0d expected %0d", no, ne); end
            for (int k = 0; k < no && k < ne; k++) begin
                checks++;
                if (obs_q[obs_rd+k].d !== exp_q[exp_rd+k].d || obs_q[obs_rd+k].t !== exp_q[exp_rd+k].t) begin
                    failures++; $display("FAIL random_out%0d: got %h@%0d expected %h@%0d", k, obs_q[obs_rd+k].d, obs_q[obs_rd+k].t, exp_q[exp_rd+k].d, exp_q[exp_rd+k].t);
                end
            end
        end
        checks++; if (overflow !== m_ovf || drop_cnt !== 16'(m_drop)) begin failures++; $display("FAIL random_stats: got ovf=%b drop=%0d expected %b/%0d", overflow, drop_cnt, m_ovf, m_drop); end
        obs_rd = obs_q.size(); exp_rd = exp_q.size();
    endtask

    task automatic test_drop_saturation();
        clr = 1'b1;
        start_clean(3'd0);
        clr       = 1'b0;
        fifo_full = 1'b1;
        in_valid  = 1'b1;
        in_data   = 24'h123456;
        idle(65540);
        in_valid = 1'b0;
        idle(2);
        fifo_full = 1'b0;
        idle(1);
        checks++; if (drop_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_drop: got %h expected %h", drop_cnt, 16'hFFFF); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL sat_ovf: got %b expected 1", overflow); end
        checks++; if (16'(m_drop) !== drop_cnt) begin failures++; $display("FAIL sat_model: got %0d expected %0d", drop_cnt, m_drop); end
        checks++; if (obs_q.size() !== obs_rd) begin failures++; $display("FAIL sat_no_write: got %0d strobes expected 0", obs_q.size() - obs_rd); end
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        checks++; if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin failures++; $display("FAIL sat_clr: got ovf=%b drop=%0d expected 0/0", overflow, drop_cnt); end
        obs_rd = obs_q.size(); exp_rd = exp_q.size();
    endtask

    initial begin
        #1;
        test_reset();
        test_avg4();
        test_floor2();
        test_pass1();
        test_fifo_full();
        test_flush();
        test_log2_change();
        test_random();
        test_drop_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
